// File: rtl/vram_boot_pkg.sv
// Shared types and constants for the VRAM boot/clear fill engine.
package vram_boot_pkg;

  localparam int unsigned VRAM_AW = 10;
  localparam int unsigned VRAM_DW = 8;

  localparam logic [VRAM_DW-1:0] FILL_CHAR_DEF = 8'h20;

  typedef logic [1:0] state_t;

  localparam state_t ST_FILL  = 2'd0;
  localparam state_t ST_FLUSH = 2'd1;
  localparam state_t ST_IDLE  = 2'd2;

  // One VRAM port-A write: address plus data byte.
  typedef struct packed {
    logic [VRAM_AW-1:0] ada;
    logic [VRAM_DW-1:0] din;
  } vram_wr_t;

  // Font test screen: glyph code equals the low address byte.
  function automatic logic [VRAM_DW-1:0] pattern_byte(input logic [VRAM_AW-1:0] ada);
    return ada[VRAM_DW-1:0];
  endfunction

endpackage

// File: rtl/vram_boot_fill.sv
// Owns VRAM write port A: sweeps a fill byte over all cells after reset or clear_req,
// parks CPU writes arriving meanwhile in a one-entry buffer, then passes CPU writes through.
// Optional macro VRAM_BOOT_PATTERN_EN: fill byte is the low address byte instead of FILL_CHAR.
module vram_boot_fill
  import vram_boot_pkg::*;
#(
  parameter int unsigned          DEPTH     = 1024,
  parameter logic [VRAM_DW-1:0]   FILL_CHAR = FILL_CHAR_DEF
) (
  input  logic               MEMORY_CLK,
  input  logic               rst,
  input  logic               clear_req,
  input  logic               cpu_v_cea,
  input  logic [VRAM_AW-1:0] cpu_v_ada,
  input  logic [VRAM_DW-1:0] cpu_v_din,
  output logic               v_cea,
  output logic [VRAM_AW-1:0] v_ada,
  output logic [VRAM_DW-1:0] v_din,
  output logic               busy,
  output logic               done,
  output logic               drop_err
);

  localparam int unsigned    CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  vram_wr_t            buf_q, buf_d;
  logic                buf_vld_q, buf_vld_d;
  logic                fill_end_q, fill_end_d;
  logic                drop_err_d;

  logic                v_cea_d;
  logic [VRAM_AW-1:0]  v_ada_d;
  logic [VRAM_DW-1:0]  v_din_d;
  logic                busy_d;

  logic [VRAM_AW-1:0]  fill_addr;
  logic [VRAM_DW-1:0]  fill_byte;
  logic                capture_en;
  vram_wr_t            cpu_wr;

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    fill_end_d = 1'b0;
    drop_err_d = drop_err;
    v_cea_d    = 1'b0;
    v_ada_d    = '0;
    v_din_d    = '0;
    busy_d     = 1'b1;
    capture_en = 1'b0;

    cpu_wr.ada = cpu_v_ada;
    cpu_wr.din = cpu_v_din;

    fill_addr  = VRAM_AW'(cnt_q);
`ifdef VRAM_BOOT_PATTERN_EN
    fill_byte  = pattern_byte(fill_addr);
`else
    fill_byte  = FILL_CHAR;
`endif

    case (state_q)
      ST_FILL: begin
        v_cea_d    = 1'b1;
        v_ada_d    = fill_addr;
        v_din_d    = fill_byte;
        capture_en = 1'b1;
        if (cnt_q == LAST_IDX) begin
          fill_end_d = 1'b1;
          // A write captured on this very edge must still be replayed.
          state_d    = (buf_vld_q || cpu_v_cea) ? ST_FLUSH : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_FLUSH: begin
        v_cea_d    = 1'b1;
        v_ada_d    = buf_q.ada;
        v_din_d    = buf_q.din;
        buf_vld_d  = 1'b0;
        capture_en = 1'b1;
        state_d    = ST_IDLE;
      end

      ST_IDLE: begin
        if (clear_req) begin
          state_d    = ST_FILL;
          cnt_d      = '0;
          capture_en = 1'b1;
        end else begin
          busy_d  = 1'b0;
          v_cea_d = cpu_v_cea;
          v_ada_d = cpu_v_ada;
          v_din_d = cpu_v_din;
        end
      end

      default: begin
        state_d = ST_FILL;
        cnt_d   = '0;
      end
    endcase

    // Buffer is sampled before this edge's flush, so a write during FLUSH is lost.
    if (capture_en && cpu_v_cea) begin
      if (buf_vld_q) begin
        drop_err_d = 1'b1;
      end else begin
        buf_d     = cpu_wr;
        buf_vld_d = 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge MEMORY_CLK) begin
    if (rst) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      fill_end_q <= 1'b0;
      drop_err   <= 1'b0;
      v_cea      <= 1'b0;
      v_ada      <= '0;
      v_din      <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      fill_end_q <= fill_end_d;
      drop_err   <= drop_err_d;
      v_cea      <= v_cea_d;
      v_ada      <= v_ada_d;
      v_din      <= v_din_d;
      busy       <= busy_d;
      done       <= fill_end_q;
    end
  end

endmodule

// File: tb/tb_vram_boot_fill.sv
// Self-checking bench for vram_boot_fill: cycle-level reference model plus pinned literals.
module tb_vram_boot_fill;

  localparam int DEPTH = 1024;

`ifdef VRAM_BOOT_PATTERN_EN
  localparam logic [7:0] L_004 = 8'h04, L_011 = 8'h11, L_030 = 8'h30,
                         L_040 = 8'h40, L_141 = 8'h41, L_3FF = 8'hFF;
`else
  localparam logic [7:0] L_004 = 8'h20, L_011 = 8'h20, L_030 = 8'h20,
                         L_040 = 8'h20, L_141 = 8'h20, L_3FF = 8'h20;
`endif

  logic       MEMORY_CLK = 1'b0;
  logic       rst        = 1'b1;
  logic       clear_req  = 1'b0;
  logic       cpu_v_cea  = 1'b0;
  logic [9:0] cpu_v_ada  = '0;
  logic [7:0] cpu_v_din  = '0;
  logic       v_cea, busy, done, drop_err;
  logic [9:0] v_ada;
  logic [7:0] v_din;

  vram_boot_fill #(.DEPTH(DEPTH), .FILL_CHAR(8'h20)) dut (
    .MEMORY_CLK(MEMORY_CLK), .rst(rst), .clear_req(clear_req),
    .cpu_v_cea(cpu_v_cea), .cpu_v_ada(cpu_v_ada), .cpu_v_din(cpu_v_din),
    .v_cea(v_cea), .v_ada(v_ada), .v_din(v_din),
    .busy(busy), .done(done), .drop_err(drop_err)
  );

  always #5 MEMORY_CLK = ~MEMORY_CLK;

  int checks = 0;
  int errors = 0;
  int rel    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, rel);
    end
  endtask

  function automatic logic [7:0] fill_of(input int a);
`ifdef VRAM_BOOT_PATTERN_EN
    return 8'(a & 255);
`else
    return 8'h20;
`endif
  endfunction

  // Reference model: a fill started at edge S writes cell k-1 at edge S+k.
  int         e = 0, start_e = 0, done_e = -1, k;
  bit         active = 1'b1, pend = 1'b0, derr = 1'b0, idle_edge;
  logic [9:0] pend_a;
  logic [7:0] pend_d;
  logic       s_rst, s_clr, s_we;
  logic [9:0] s_a;
  logic [7:0] s_d;
  logic       x_cea, x_busy, x_done;
  logic [9:0] x_ada;
  logic [7:0] x_din;

  // Observations of the DUT port used by the pinned checks.
  logic [7:0] vram   [0:DEPTH-1];
  int         wr_rel [0:DEPTH-1];
  int         first_done_rel = -1, busy_fall_rel = -1;
  int         first_wr_rel = -1;
  logic [9:0] first_wr_ada = '0;

  always begin
    @(posedge MEMORY_CLK);
    s_rst = rst; s_clr = clear_req; s_we = cpu_v_cea; s_a = cpu_v_ada; s_d = cpu_v_din;
    #1;
    x_cea = 1'b0; x_ada = '0; x_din = '0; x_busy = 1'b1;
    if (s_rst) begin
      start_e = e; active = 1'b1; pend = 1'b0; derr = 1'b0; done_e = -1; rel = 0;
    end else begin
      rel++;
      idle_edge = !active;
      if (active) begin
        k = e - start_e;
        if (k <= DEPTH) begin
          x_cea = 1'b1; x_ada = 10'(k - 1); x_din = fill_of(k - 1);
          if (s_we) begin
            if (pend) derr = 1'b1;
            else begin pend = 1'b1; pend_a = s_a; pend_d = s_d; end
          end
          if (k == DEPTH) done_e = e + 1;
        end else if (pend) begin
          x_cea = 1'b1; x_ada = pend_a; x_din = pend_d;
          if (s_we) derr = 1'b1;
          pend = 1'b0; active = 1'b0;
        end else begin
          active = 1'b0; idle_edge = 1'b1;
        end
      end
      if (idle_edge) begin
        if (s_clr) begin
          start_e = e; active = 1'b1;
          if (s_we) begin pend = 1'b1; pend_a = s_a; pend_d = s_d; end
        end else begin
          x_busy = 1'b0; x_cea = s_we; x_ada = s_a; x_din = s_d;
        end
      end
    end
    x_done = (e == done_e);

    chk("v_cea", 32'(v_cea), 32'(x_cea));
    chk("v_ada", 32'(v_ada), 32'(x_ada));
    chk("v_din", 32'(v_din), 32'(x_din));
    chk("busy", 32'(busy), 32'(x_busy));
    chk("done", 32'(done), 32'(x_done));
    chk("drop_err", 32'(drop_err), 32'(derr));

    if (s_rst) begin
      first_done_rel = -1; busy_fall_rel = -1; first_wr_rel = -1;
    end else begin
      if (v_cea === 1'b1) begin
        vram[v_ada] = v_din;
        wr_rel[v_ada] = rel;
        if (first_wr_rel < 0) begin first_wr_rel = rel; first_wr_ada = v_ada; end
      end
      if (done === 1'b1 && first_done_rel < 0) first_done_rel = rel;
      if (busy === 1'b0 && busy_fall_rel < 0) busy_fall_rel = rel;
    end
    e++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge MEMORY_CLK);
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [7:0] d, input logic clr);
    cpu_v_cea = 1'b1; cpu_v_ada = a; cpu_v_din = d; clear_req = clr;
    cyc(1);
    cpu_v_cea = 1'b0; clear_req = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    cyc(1);
    clear_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    cyc(2);
    while (busy !== 1'b0 && n < 3000) begin cyc(1); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic random_traffic(input int n, input int clr_mod);
    for (int i = 0; i < n; i++) begin
      cpu_v_cea = ($urandom_range(0, 3) == 0);
      cpu_v_ada = 10'($urandom);
      cpu_v_din = 8'($urandom);
      clear_req = (clr_mod > 0) && ($urandom_range(0, clr_mod - 1) == 0);
      cyc(1);
    end
    cpu_v_cea = 1'b0; clear_req = 1'b0;
  endtask

  initial begin
    // Boot fill with one CPU write parked at fill cycle 100.
    cyc(3);
    rst = 1'b0;
    cyc(99);
    cpu_write(10'h005, 8'h7E, 1'b0);
    wait_idle("boot_idle");
    chk("boot_done_cycle", 32'(first_done_rel), 32'd1025);
    chk("boot_busy_fall", 32'(busy_fall_rel), 32'd1026);
    chk("boot_flush_cycle", 32'(wr_rel[10'h005]), 32'd1025);
    chk("boot_cell_005", 32'(vram[10'h005]), 32'h7E);
    chk("boot_cell_004", 32'(vram[10'h004]), 32'(L_004));
    chk("boot_cell_141", 32'(vram[10'h141]), 32'(L_141));
    chk("boot_cell_3ff", 32'(vram[10'h3FF]), 32'(L_3FF));
    chk("boot_cell_3ff_cycle", 32'(wr_rel[10'h3FF]), 32'd1024);
    chk("boot_drop_err", 32'(drop_err), 32'd0);

    random_traffic(150, 0);

    // clear_req and CPU write on the same idle cycle.
    cpu_write(10'h010, 8'h55, 1'b1);
    chk("clr_busy_next", 32'(busy), 32'd1);
    chk("clr_ada_next", 32'(v_ada), 32'd0);
    wait_idle("clr_idle");
    chk("clr_cell_010", 32'(vram[10'h010]), 32'h55);
    chk("clr_cell_011", 32'(vram[10'h011]), 32'(L_011));
    chk("clr_drop_err", 32'(drop_err), 32'd0);

    // Two CPU writes during one fill: first replayed, second lost.
    pulse_clear();
    cyc(10);
    cpu_write(10'h020, 8'hA5, 1'b0);
    cyc(5);
    cpu_write(10'h030, 8'h5A, 1'b0);
    wait_idle("drop_idle");
    chk("drop_cell_020", 32'(vram[10'h020]), 32'hA5);
    chk("drop_cell_030", 32'(vram[10'h030]), 32'(L_030));
    chk("drop_err_set", 32'(drop_err), 32'd1);
    random_traffic(50, 0);
    chk("drop_err_sticky", 32'(drop_err), 32'd1);

    // Random writes and clear requests in and out of fills.
    random_traffic(2600, 200);
    wait_idle("rand_idle");

    // Reset in the middle of a fill discards the buffered write.
    pulse_clear();
    cyc(100);
    cpu_write(10'h040, 8'hC3, 1'b0);
    cyc(398);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    wait_idle("rst_idle");
    chk("rst_first_wr_cycle", 32'(first_wr_rel), 32'd1);
    chk("rst_first_wr_ada", 32'(first_wr_ada), 32'd0);
    chk("rst_busy_fall", 32'(busy_fall_rel), 32'd1025);
    chk("rst_cell_040", 32'(vram[10'h040]), 32'(L_040));

    random_traffic(40, 0);
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
